// File: rtl/a7_ddr3_rd_ctrl.sv
// a7_ddr3_rd_ctrl
// Read-side controller for the Artix-7 DDR3 MIG user interface. A user burst-read
// request is split into one MIG read command per 128-bit beat; returned beats are
// forwarded to the user with one cycle of latency and rd_end marks the last beat.

module a7_ddr3_rd_ctrl #(
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic          sclk,
    input  logic          rst,

    // User command side
    input  logic          rd_cmd_start,
    input  logic [2:0]    rd_cmd_instr,
    input  logic [6:0]    rd_cmd_bl,
    input  logic [27:0]   rd_cmd_addr,

    // User data side
    output logic          rd_data_valid,
    output logic [127:0]  rd_data_128bit,
    output logic          rd_end,
    output logic          rd_busy,

    // MIG app_* command port
    output logic          app_en,
    input  logic          app_rdy,
    output logic [27:0]   app_addr,
    output logic [2:0]    app_cmd,

    // MIG read data return
    input  logic [127:0]  app_rd_data,
    input  logic          app_rd_data_valid
);

    localparam logic [27:0] AddrInc = 28'(ADDR_STEP);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCmd      = 2'd1,
        StWaitData = 2'd2
    } state_e;

    state_e         state_q, state_d;

    // Latched request fields
    logic [2:0]     instr_q, instr_d;
    logic [6:0]     bl_q, bl_d;
    logic [27:0]    addr_q, addr_d;

    // Commands accepted / beats delivered within the current burst
    logic [6:0]     cmd_cnt_q, cmd_cnt_d;
    logic [6:0]     data_cnt_q, data_cnt_d;

    // Registered user outputs
    logic           rd_valid_q, rd_valid_d;
    logic [127:0]   rd_data_q, rd_data_d;
    logic           rd_end_q, rd_end_d;

    logic           start_ok;
    logic           cmd_acc;
    logic           last_cmd;
    logic           data_beat;
    logic           last_data;
    logic [6:0]     bl_last;

    // Decode of the events that drive both the FSM and the datapath
    always_comb begin
        bl_last   = bl_q - 7'd1;
        // A zero-length start is dropped silently; starts outside IDLE are ignored.
        start_ok  = (state_q == StIdle) && rd_cmd_start && (rd_cmd_bl != 7'd0);
        cmd_acc   = (state_q == StCmd) && app_rdy;
        last_cmd  = cmd_acc && (cmd_cnt_q == bl_last);
        // Data may come back while commands are still being issued, so the data
        // path listens in CMD as well; beats arriving in IDLE are strays.
        data_beat = (state_q != StIdle) && app_rd_data_valid;
        // Completion only once every command has been accepted.
        last_data = (state_q == StWaitData) && app_rd_data_valid && (data_cnt_q == bl_last);
    end

    // FSM state register
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (last_cmd) begin
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                if (last_data) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: command valid and busy follow the state directly
    always_comb begin
        app_en   = (state_q == StCmd);
        app_addr = addr_q;
        app_cmd  = instr_q;
        rd_busy  = (state_q != StIdle);
    end

    // Datapath next-state: request latch, address/counter advance, data capture
    always_comb begin
        instr_d    = instr_q;
        bl_d       = bl_q;
        addr_d     = addr_q;
        cmd_cnt_d  = cmd_cnt_q;
        data_cnt_d = data_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_end_d   = last_data;

        if (start_ok) begin
            instr_d    = rd_cmd_instr;
            bl_d       = rd_cmd_bl;
            addr_d     = rd_cmd_addr;
            cmd_cnt_d  = 7'd0;
            data_cnt_d = 7'd0;
        end

        if (cmd_acc) begin
            cmd_cnt_d = cmd_cnt_q + 7'd1;
            // 28-bit add wraps modulo 2^28 by construction.
            addr_d    = addr_q + AddrInc;
        end

        if (data_beat) begin
            data_cnt_d = data_cnt_q + 7'd1;
            rd_valid_d = 1'b1;
            rd_data_d  = app_rd_data;
        end
    end

    // Datapath registers
    always_ff @(posedge sclk) begin
        if (rst) begin
            instr_q    <= 3'd0;
            bl_q       <= 7'd0;
            addr_q     <= 28'd0;
            cmd_cnt_q  <= 7'd0;
            data_cnt_q <= 7'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 128'd0;
            rd_end_q   <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            bl_q       <= bl_d;
            addr_q     <= addr_d;
            cmd_cnt_q  <= cmd_cnt_d;
            data_cnt_q <= data_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_end_q   <= rd_end_d;
        end
    end

    // Registered user-side outputs
    always_comb begin
        rd_data_valid  = rd_valid_q;
        rd_data_128bit = rd_data_q;
        rd_end         = rd_end_q;
    end

endmodule

// File: tb/tb_a7_ddr3_rd_ctrl.sv
// Testbench for a7_ddr3_rd_ctrl: directed bursts against a small MIG model that
// returns one beat per accepted command a fixed delay later. Expected commands and
// beats are queued when a burst is started and popped as the DUT produces them.

module tb_a7_ddr3_rd_ctrl;

    logic          sclk;
    logic          rst;
    logic          rd_cmd_start;
    logic [2:0]    rd_cmd_instr;
    logic [6:0]    rd_cmd_bl;
    logic [27:0]   rd_cmd_addr;
    logic          rd_data_valid;
    logic [127:0]  rd_data_128bit;
    logic          rd_end;
    logic          rd_busy;
    logic          app_en;
    logic          app_rdy;
    logic [27:0]   app_addr;
    logic [2:0]    app_cmd;
    logic [127:0]  app_rd_data;
    logic          app_rd_data_valid;

    a7_ddr3_rd_ctrl #(
        .ADDR_STEP(8)
    ) dut (
        .sclk              (sclk),
        .rst               (rst),
        .rd_cmd_start      (rd_cmd_start),
        .rd_cmd_instr      (rd_cmd_instr),
        .rd_cmd_bl         (rd_cmd_bl),
        .rd_cmd_addr       (rd_cmd_addr),
        .rd_data_valid     (rd_data_valid),
        .rd_data_128bit    (rd_data_128bit),
        .rd_end            (rd_end),
        .rd_busy           (rd_busy),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid)
    );

    typedef struct {
        int unsigned  due;
        logic [27:0]  addr;
    } ret_t;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    int unsigned   cyc = 0;
    int unsigned   acc_cnt = 0;
    int unsigned   end_cnt = 0;
    logic          prev_app_valid = 1'b0;

    logic [27:0]   exp_cmd[$];
    beat_t         exp_data[$];
    ret_t          ret_q[$];

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [127:0] data_of(input logic [27:0] a);
        return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // MIG read-data model: returns accepted commands in order, 4 cycles after accept
    initial begin
        ret_t r;
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        forever begin
            @(posedge sclk);
            #1;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                r = ret_q.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data       = data_of(r.addr);
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    // Monitor: command port and user data port against the scoreboard
    always @(negedge sclk) begin
        beat_t b;
        ret_t  r;
        if (!rst) begin
            if (app_en) begin
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", {127'd0, app_en}, 128'd0);
                end else begin
                    chk("cmd_addr", {100'd0, app_addr}, {100'd0, exp_cmd[0]});
                    chk("cmd_code", {125'd0, app_cmd}, 128'd1);
                    if (app_rdy) begin
                        void'(exp_cmd.pop_front());
                        acc_cnt++;
                        r.due  = cyc + 5;
                        r.addr = app_addr;
                        ret_q.push_back(r);
                    end
                end
            end
            if (rd_data_valid) begin
                chk("rd_latency", {127'd0, prev_app_valid}, 128'd1);
                if (exp_data.size() == 0) begin
                    chk("rd_unexpected", {127'd0, rd_data_valid}, 128'd0);
                end else begin
                    b = exp_data.pop_front();
                    chk("rd_data", rd_data_128bit, b.data);
                    chk("rd_end_flag", {127'd0, rd_end}, {127'd0, b.last});
                end
            end
            if (rd_end) begin
                end_cnt++;
                chk("rd_end_with_valid", {127'd0, rd_data_valid}, 128'd1);
                chk("rd_busy_at_end", {127'd0, rd_busy}, 128'd0);
            end
        end
        prev_app_valid = app_rd_data_valid;
    end

    // Caller is just after a rising edge; leaves just after the next one.
    task automatic start_burst(input logic [6:0] bl, input logic [27:0] addr,
                               input logic expect_cmd);
        beat_t       b;
        logic [27:0] a;
        a = addr;
        for (int i = 0; i < int'(bl); i++) begin
            exp_cmd.push_back(a);
            b.data = data_of(a);
            b.last = (i == int'(bl) - 1);
            exp_data.push_back(b);
            a = a + 28'd8;
        end
        rd_cmd_start = 1'b1;
        rd_cmd_instr = 3'b001;
        rd_cmd_bl    = bl;
        rd_cmd_addr  = addr;
        @(posedge sclk);
        #1;
        rd_cmd_start = 1'b0;
        chk("first_cmd_en", {127'd0, app_en}, {127'd0, expect_cmd});
        if (expect_cmd) begin
            chk("first_cmd_addr", {100'd0, app_addr}, {100'd0, addr});
        end
    endtask

    task automatic wait_end(input int unsigned target, input string tag);
        for (int i = 0; i < 300 && end_cnt < target; i++) begin
            @(posedge sclk);
            #1;
        end
        chk({tag, "_end_cnt"}, 128'(end_cnt), 128'(target));
        chk({tag, "_cmd_q_empty"}, 128'(exp_cmd.size()), 128'd0);
        chk({tag, "_data_q_empty"}, 128'(exp_data.size()), 128'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_app_en"}, {127'd0, app_en}, 128'd0);
        chk({tag, "_rd_data_valid"}, {127'd0, rd_data_valid}, 128'd0);
        chk({tag, "_rd_data"}, rd_data_128bit, 128'd0);
        chk({tag, "_rd_end"}, {127'd0, rd_end}, 128'd0);
        chk({tag, "_rd_busy"}, {127'd0, rd_busy}, 128'd0);
    endtask

    logic        rdy_pat[7];
    int unsigned acc_base;

    initial begin
        rst          = 1'b1;
        rd_cmd_start = 1'b0;
        rd_cmd_instr = 3'b000;
        rd_cmd_bl    = 7'd0;
        rd_cmd_addr  = 28'd0;
        app_rdy      = 1'b1;
        rdy_pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge sclk);
        #1;
        check_idle("reset");
        chk("reset_app_addr", {100'd0, app_addr}, 128'd0);
        chk("reset_app_cmd", {125'd0, app_cmd}, 128'd0);
        rst = 1'b0;
        @(posedge sclk);
        #1;

        // Single beat
        start_burst(7'd1, 28'h100, 1'b1);
        wait_end(1, "single");

        // Burst with backpressure
        acc_base = acc_cnt;
        start_burst(7'd4, 28'h200, 1'b1);
        for (int i = 1; i < 7; i++) begin
            @(posedge sclk);
            #1;
            app_rdy = rdy_pat[i];
        end
        app_rdy = 1'b1;
        wait_end(2, "backpressure");
        chk("backpressure_accepts", 128'(acc_cnt - acc_base), 128'd4);

        // Start while busy is ignored
        acc_base = acc_cnt;
        start_burst(7'd8, 28'h600, 1'b1);
        @(posedge sclk);
        #1;
        rd_cmd_start = 1'b1;
        rd_cmd_bl    = 7'd2;
        rd_cmd_addr  = 28'h900;
        @(posedge sclk);
        #1;
        rd_cmd_start = 1'b0;
        wait_end(3, "busy_start");
        repeat (10) @(posedge sclk);
        #1;
        chk("busy_start_accepts", 128'(acc_cnt - acc_base), 128'd8);
        chk("busy_start_single_end", 128'(end_cnt), 128'd3);

        // Back-to-back: second start in the rd_end cycle
        start_burst(7'd3, 28'h500, 1'b1);
        for (int i = 0; i < 100 && rd_end !== 1'b1; i++) begin
            @(posedge sclk);
            #1;
        end
        chk("b2b_rd_end_seen", {127'd0, rd_end}, 128'd1);
        start_burst(7'd2, 28'h400, 1'b1);
        wait_end(5, "b2b");

        // Address wrap
        start_burst(7'd2, 28'hFFFFFF8, 1'b1);
        wait_end(6, "wrap");

        // Zero length start is dropped
        start_burst(7'd0, 28'h700, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("zero_len_busy", {127'd0, rd_busy}, 128'd0);
            chk("zero_len_en", {127'd0, app_en}, 128'd0);
            @(posedge sclk);
            #1;
        end
        chk("zero_len_no_end", 128'(end_cnt), 128'd6);

        // Reset mid-burst after two accepts, then stray beats
        acc_base = acc_cnt;
        start_burst(7'd4, 28'h300, 1'b1);
        for (int i = 0; i < 50 && acc_cnt < acc_base + 2; i++) begin
            @(negedge sclk);
        end
        chk("mid_reset_accepts", 128'(acc_cnt - acc_base), 128'd2);
        @(posedge sclk);
        #1;
        rst     = 1'b1;
        app_rdy = 1'b0;
        exp_cmd.delete();
        exp_data.delete();
        @(posedge sclk);
        #1;
        rst     = 1'b0;
        app_rdy = 1'b1;
        check_idle("mid_reset");
        chk("mid_reset_app_addr", {100'd0, app_addr}, 128'd0);
        chk("mid_reset_app_cmd", {125'd0, app_cmd}, 128'd0);
        repeat (10) @(posedge sclk);
        #1;
        check_idle("after_stray");
        chk("after_stray_no_end", 128'(end_cnt), 128'd6);

        start_burst(7'd1, 28'h1000, 1'b1);
        wait_end(7, "post_reset");

        repeat (5) @(posedge sclk);
        #1;
        chk("final_end_cnt", 128'(end_cnt), 128'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
